tpu_c_drain: RTL and testbench

- Downstream stage of the TPU. After the TPU drops busy, this block reads the result global buffer C, one 128-bit word at a time.
- Each 128-bit word is serialised into four 32-bit results on a valid/ready stream towards the host/DMA side.
- Owns the C buffer read port only while draining. An external mux selects TPU vs drain using drain_busy.

---
 rtl/tpu_c_drain_pkg.sv | 20 ++
 rtl/tpu_c_drain_if.sv | 12 +
 rtl/tpu_c_drain_serializer.sv | 46 ++++
 rtl/tpu_c_drain.sv | 99 +++++++++
 tb/tb_tpu_c_drain.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tpu_c_drain_pkg.sv
// Shared definitions for the C-buffer drain: lane count, FSM encoding and
// the order in which the 32-bit lanes of a C word are emitted.
package tpu_c_drain_pkg;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_FIN
  } drain_state_t;

  // Lane 0 is the most significant element of a C word.
  function automatic int lane_lsb(input int lane, input int data_bits);
    return (LANES - 1 - lane) * data_bits;
  endfunction

endpackage

// File: rtl/tpu_c_drain_if.sv
// Result stream from the drain towards the host/DMA side (valid/ready).
interface tpu_c_drain_if #(
  parameter int DATA_BITS = 32
);
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/tpu_c_drain_serializer.sv
// Holds one C word and emits its lanes, most significant first, on the
// valid/ready stream; the lane index only advances on an accepted transfer.
module tpu_word_serializer
  import tpu_c_drain_pkg::*;
#(
  parameter int DATA_BITS  = 32,
  parameter int DATAC_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  active,
  input  logic                  last_word,
  input  logic [DATAC_BITS-1:0] word,
  output logic                  lane_done,
  tpu_c_drain_if.master         out
);

  localparam int LANE_W = $clog2(LANES);

  logic [DATAC_BITS-1:0] hold;
  logic [LANE_W-1:0]     lane;
  logic                  lane_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      lane <= '0;
    end else if (load) begin
      hold <= word;
      lane <= '0;
    end else if (active && out.out_ready) begin
      lane <= lane + LANE_W'(1);
    end
  end

  assign lane_end = (lane == LANE_W'(LANES - 1));

  always_comb begin
    out.out_valid = active;
    out.out_data  = DATA_BITS'(hold >> lane_lsb(int'(lane), DATA_BITS));
    out.out_last  = active && lane_end && last_word;
    lane_done     = active && out.out_ready && lane_end;
  end

endmodule

// File: rtl/tpu_c_drain.sv
// Drains the C global buffer after a TPU job: reads M*ceil(N/4) words in
// linear order and hands each to the serializer as four 32-bit results.
module tpu_c_drain
  import tpu_c_drain_pkg::*;
#(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BITS  = 32,
  parameter int DATAC_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            M,
  input  logic [7:0]            N,
  output logic                  drain_busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  C_index,
  input  logic [DATAC_BITS-1:0] C_data_out,
  tpu_c_drain_if.master         out
);

  drain_state_t state, state_next;

  logic [15:0] total;
  logic [15:0] word_cnt;
  logic [15:0] start_total;
  logic [6:0]  blk;
  logic        lane_done;
  logic        last_word;
  logic        load;
  logic        active;

  // Column blocks per row round N up to whole 4-lane words.
  assign blk         = 7'((9'(N) + 9'd3) >> 2);
  assign start_total = 16'(M) * 16'(blk);
  assign last_word   = (word_cnt + 16'd1 == total);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      total    <= '0;
      word_cnt <= '0;
      C_index  <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) begin
        total    <= start_total;
        word_cnt <= '0;
        C_index  <= '0;
      end else if (lane_done) begin
        word_cnt <= word_cnt + 16'd1;
        if (!last_word) C_index <= ADDR_BITS'(word_cnt + 16'd1);
      end
    end
  end

  always_comb begin
    state_next = state;
    drain_busy = 1'b1;
    done       = 1'b0;
    load       = 1'b0;
    active     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        drain_busy = 1'b0;
        if (start) state_next = (start_total == 16'd0) ? ST_FIN : ST_READ;
      end
      ST_READ: state_next = ST_WAIT;
      ST_WAIT: begin
        load       = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        active = 1'b1;
        if (lane_done) state_next = last_word ? ST_FIN : ST_READ;
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  tpu_word_serializer #(
    .DATA_BITS (DATA_BITS),
    .DATAC_BITS(DATAC_BITS)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .active   (active),
    .last_word(last_word),
    .word     (C_data_out),
    .lane_done(lane_done),
    .out      (out)
  );

endmodule

// File: tb/tb_tpu_c_drain.sv
// Directed and randomized drain jobs checked against a queue-based model of
// the expected result stream.
module tb_tpu_c_drain;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   M;
  logic [7:0]   N;
  logic         drain_busy;
  logic         done;
  logic [15:0]  C_index;
  logic [127:0] C_data_out;
  logic [127:0] mem [64];

  int tests;
  int failures;

  tpu_c_drain_if #(.DATA_BITS(32)) out_if ();

  tpu_c_drain #(
    .ADDR_BITS (16),
    .DATA_BITS (32),
    .DATAC_BITS(128)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .M         (M),
    .N         (N),
    .drain_busy(drain_busy),
    .done      (done),
    .C_index   (C_index),
    .C_data_out(C_data_out),
    .out       (out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read C buffer: data one cycle after the address.
  always_ff @(posedge clk) C_data_out <= mem[C_index[5:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic run_job(input int m, input int n, input int mode,
                         input int inj_cycle, input int inj_m);
    logic [31:0] expq[$];
    int total, budget, cyc, first_valid, done_cyc, emitted, exp_word;
    bit got_done, held_valid;
    logic [31:0] held_data;
    int pat[4] = '{1, 0, 0, 1};

    total = m * ((n + 3) / 4);
    for (int w = 0; w < total; w++)
      for (int l = 0; l < 4; l++)
        expq.push_back(32'(mem[w] >> (96 - 32 * l)));

    start = 1'b1;
    M = 8'(m);
    N = 8'(n);
    out_if.out_ready = 1'b1;
    check("busy_at_start", drain_busy, 1'b0);
    step();
    start = 1'b0;
    cyc = 1;
    budget = 40 * total + 40;
    got_done = 0; held_valid = 0; held_data = '0;
    first_valid = -1; done_cyc = -1; emitted = 0; exp_word = 0;

    while (!got_done && cyc < budget) begin
      if (cyc == inj_cycle) begin
        start = 1'b1;
        M = 8'(inj_m);
        N = 8'(n + 4);
      end else begin
        start = 1'b0;
      end
      case (mode)
        1:       out_if.out_ready = 1'($urandom_range(0, 1));
        2:       out_if.out_ready = 1'(pat[cyc % 4]);
        default: out_if.out_ready = 1'b1;
      endcase
      check("busy_during", drain_busy, 1'b1);
      if (held_valid) check("hold_stable", {out_if.out_valid, out_if.out_data}, {1'b1, held_data});
      if (out_if.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (expq.size() == 0) begin
          check("extra_element", 1'b1, 1'b0);
        end else begin
          check("data", out_if.out_data, expq[0]);
          check("last", out_if.out_last, expq.size() == 1);
          check("c_index", C_index, 16'(exp_word));
          if (out_if.out_ready) begin
            void'(expq.pop_front());
            emitted++;
            if (emitted % 4 == 0) exp_word++;
          end
        end
      end else begin
        check("last_idle", out_if.out_last, 1'b0);
      end
      held_valid = out_if.out_valid && !out_if.out_ready;
      held_data  = out_if.out_data;
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
        check("count", emitted, 4 * total);
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (!got_done) check("timeout", 1'b0, 1'b1);
    if (mode == 0 && inj_cycle < 0) begin
      check("done_cycle", done_cyc, (total == 0) ? 1 : 1 + 6 * total);
      if (total > 0) check("first_valid_cycle", first_valid, 3);
    end
    check("busy_after", drain_busy, 1'b0);
    check("done_single", done, 1'b0);
    check("valid_after", out_if.out_valid, 1'b0);
  endtask

  initial begin
    tests = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    M = '0;
    N = '0;
    out_if.out_ready = 1'b0;
    fill_random();
    step();
    check("rst_busy", drain_busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", out_if.out_valid, 1'b0);
    check("rst_data", out_if.out_data, 32'h0);
    check("rst_last", out_if.out_last, 1'b0);
    check("rst_cindex", C_index, 16'h0);
    rst_n = 1'b1;
    step();

    // Single word, ready held high: lanes 1,2,3,4 and exact timing.
    mem[0] = 128'h00000001_00000002_00000003_00000004;
    run_job(1, 4, 0, -1, 0);

    // Four words, each word carrying its own index in every lane.
    for (int i = 0; i < 64; i++) mem[i] = {4{32'(i)}};
    run_job(2, 8, 0, -1, 0);

    // Backpressure pattern across a multi-word job.
    fill_random();
    run_job(4, 4, 2, -1, 0);

    // Empty job: done right after start, no data.
    run_job(0, 5, 0, -1, 0);

    // Start with different M during an active drain must be ignored.
    run_job(3, 6, 0, 5, 7);

    // Padding lanes: N not a multiple of four.
    run_job(2, 5, 0, -1, 0);

    // Reset while sending.
    start = 1'b1; M = 8'd2; N = 8'd4; out_if.out_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre_reset_valid", out_if.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_valid", out_if.out_valid, 1'b0);
    check("async_busy", drain_busy, 1'b0);
    check("async_done", done, 1'b0);
    check("async_data", out_if.out_data, 32'h0);
    check("async_cindex", C_index, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    run_job(3, 5, 0, -1, 0);

    // Randomized jobs with random backpressure.
    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_job($urandom_range(0, 5), $urandom_range(0, 12), (r % 2 == 1) ? 1 : 0, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
